fw_sprite_ctrl: RTL and testbench

FW_SPRITE_CTRL -- requirements
Module: fw_sprite_ctrl

---
 rtl/fw_sprite_pkg.sv | 29 ++
 rtl/fw_sprite_anim.sv | 73 +++++++
 rtl/fw_sprite_ctrl.sv | 117 +++++++++++
 tb/tb_fw_sprite_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fw_sprite_pkg.sv
// Shared types and encodings for the sprite controller: animation states,
// move_dir codes and the frame field carried in the ROM address.
package fw_sprite_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WALK_A = 2'd1,
    WALK_B = 2'd2
  } anim_state_t;

  localparam logic [1:0] MOVE_IDLE  = 2'b00;
  localparam logic [1:0] MOVE_LEFT  = 2'b01;
  localparam logic [1:0] MOVE_RIGHT = 2'b10;
  localparam logic [1:0] MOVE_RSVD  = 2'b11;

  localparam logic [1:0] FRAME_IDLE   = 2'b00;
  localparam logic [1:0] FRAME_WALK_A = 2'b01;
  localparam logic [1:0] FRAME_WALK_B = 2'b10;

  // Frame 2'b11 is reserved; no state maps onto it.
  function automatic logic [1:0] frame_of(input anim_state_t s);
    case (s)
      WALK_A:  frame_of = FRAME_WALK_A;
      WALK_B:  frame_of = FRAME_WALK_B;
      default: frame_of = FRAME_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/fw_sprite_anim.sv
// Walk-cycle animation: state machine, per-step frame divider and facing
// register, all advanced only on frame_start from the shadowed move_dir.
module fw_sprite_anim
  import fw_sprite_pkg::*;
#(
  parameter int ANIM_DIV = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_start,
  input  logic [1:0] move_dir,
  output logic [1:0] frame,
  output logic       facing_left
);

  localparam logic [7:0] DIV_LAST = 8'(ANIM_DIV - 1);

  anim_state_t state, state_nxt;
  logic [7:0]  div, div_nxt;
  logic        facing_left_nxt;
  logic        moving;

  assign moving = (move_dir == MOVE_LEFT) || (move_dir == MOVE_RIGHT);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= IDLE;
      div         <= '0;
      facing_left <= 1'b0;
    end else begin
      state       <= state_nxt;
      div         <= div_nxt;
      facing_left <= facing_left_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    div_nxt         = div;
    facing_left_nxt = facing_left;
    if (frame_start) begin
      if (move_dir == MOVE_LEFT)       facing_left_nxt = 1'b1;
      else if (move_dir == MOVE_RIGHT) facing_left_nxt = 1'b0;

      if (!moving) begin
        state_nxt = IDLE;
        div_nxt   = '0;
      end else begin
        case (state)
          IDLE: begin
            state_nxt = WALK_A;
            div_nxt   = '0;
          end
          WALK_A, WALK_B: begin
            if (div == DIV_LAST) begin
              div_nxt   = '0;
              state_nxt = (state == WALK_A) ? WALK_B : WALK_A;
            end else begin
              div_nxt = div + 8'd1;
            end
          end
          default: begin
            state_nxt = IDLE;
            div_nxt   = '0;
          end
        endcase
      end
    end
  end

  assign frame = frame_of(state);

endmodule

// File: rtl/fw_sprite_ctrl.sv
// Sprite pixel pipeline: stage 0 hit test and mirrored address, stage 1
// ROM address register, stage 2 palette colour register.
module fw_sprite_ctrl
  import fw_sprite_pkg::*;
#(
  parameter int         SPR_W           = 32,
  parameter int         SPR_H           = 32,
  parameter int         ANIM_DIV        = 8,
  parameter logic [3:0] TRANSPARENT_IDX = 4'h0
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_start,
  input  logic        draw_valid,
  input  logic [9:0]  draw_x,
  input  logic [9:0]  draw_y,
  input  logic [9:0]  pos_x,
  input  logic [9:0]  pos_y,
  input  logic [1:0]  move_dir,
  output logic [11:0] rom_addr,
  input  logic [3:0]  rom_index,
  output logic [3:0]  pal_index,
  input  logic [3:0]  pal_red,
  input  logic [3:0]  pal_green,
  input  logic [3:0]  pal_blue,
  output logic        pix_valid,
  output logic        pix_hit,
  output logic [3:0]  pix_red,
  output logic [3:0]  pix_green,
  output logic [3:0]  pix_blue
);

  localparam int CW = $clog2(SPR_W);
  localparam int RW = $clog2(SPR_H);

  // Per-frame shadow of the sprite controls
  logic [9:0] sh_pos_x, sh_pos_y;
  logic [1:0] sh_move_dir;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sh_pos_x    <= '0;
      sh_pos_y    <= '0;
      sh_move_dir <= MOVE_IDLE;
    end else if (frame_start) begin
      sh_pos_x    <= pos_x;
      sh_pos_y    <= pos_y;
      sh_move_dir <= move_dir;
    end
  end

  logic [1:0] frame;
  logic       facing_left;

  fw_sprite_anim #(.ANIM_DIV(ANIM_DIV)) u_anim (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_start (frame_start),
    .move_dir    (sh_move_dir),
    .frame       (frame),
    .facing_left (facing_left)
  );

  // Stage 0: 11-bit signed offsets so a sprite hanging off any edge never
  // wraps back into view.
  logic signed [10:0] dx, dy;
  logic               in_x, in_y, hit0;
  logic [CW-1:0]      col;
  logic [RW-1:0]      row;
  logic [11:0]        addr0;

  assign dx   = $signed({1'b0, draw_x}) - $signed({1'b0, sh_pos_x});
  assign dy   = $signed({1'b0, draw_y}) - $signed({1'b0, sh_pos_y});
  assign in_x = !dx[10] && ({1'b0, dx[9:0]} < 11'(SPR_W));
  assign in_y = !dy[10] && ({1'b0, dy[9:0]} < 11'(SPR_H));
  assign hit0 = draw_valid && in_x && in_y;

  assign col   = facing_left ? (CW'(SPR_W - 1) - dx[CW-1:0]) : dx[CW-1:0];
  assign row   = dy[RW-1:0];
  assign addr0 = 12'({frame, row, col});

  // vld_pipe[0] is stage 1, vld_pipe[1] is stage 2 (pix_valid)
  logic [1:0] vld_pipe;
  logic       s1_hit;
  logic       opaque;

  assign pal_index = rom_index;
  assign opaque    = (rom_index != TRANSPARENT_IDX);
  assign pix_valid = vld_pipe[1];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      vld_pipe  <= '0;
      s1_hit    <= 1'b0;
      rom_addr  <= '0;
      pix_hit   <= 1'b0;
      pix_red   <= '0;
      pix_green <= '0;
      pix_blue  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[0], draw_valid};
      s1_hit   <= hit0;
      if (hit0) rom_addr <= addr0;
      pix_hit <= s1_hit && opaque;
      if (s1_hit && opaque) begin
        pix_red   <= pal_red;
        pix_green <= pal_green;
        pix_blue  <= pal_blue;
      end else begin
        pix_red   <= '0;
        pix_green <= '0;
        pix_blue  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fw_sprite_ctrl.sv
// Bench for fw_sprite_ctrl: directed vector table, scenario sequences and a
// randomized run against a behavioural sprite model.
module tb_fw_sprite_ctrl;

  localparam int DIV = 2;
  localparam int SW  = 32;
  localparam int SH  = 32;

  logic        Clk = 1'b0;
  logic        Reset, frame_start, draw_valid;
  logic [9:0]  draw_x, draw_y, pos_x, pos_y;
  logic [1:0]  move_dir;
  logic [11:0] rom_addr;
  logic [3:0]  rom_index, pal_index, pal_red, pal_green, pal_blue;
  logic        pix_valid, pix_hit;
  logic [3:0]  pix_red, pix_green, pix_blue;

  logic [3:0]  rom_mem [4096];
  logic [11:0] pal_tab [16];

  always #5 Clk = ~Clk;

  assign rom_index = rom_mem[rom_addr];
  assign {pal_red, pal_green, pal_blue} = pal_tab[pal_index];

  fw_sprite_ctrl #(.SPR_W(SW), .SPR_H(SH), .ANIM_DIV(DIV), .TRANSPARENT_IDX(4'h0)) dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .draw_valid(draw_valid),
    .draw_x(draw_x), .draw_y(draw_y), .pos_x(pos_x), .pos_y(pos_y),
    .move_dir(move_dir), .rom_addr(rom_addr), .rom_index(rom_index),
    .pal_index(pal_index), .pal_red(pal_red), .pal_green(pal_green),
    .pal_blue(pal_blue), .pix_valid(pix_valid), .pix_hit(pix_hit),
    .pix_red(pix_red), .pix_green(pix_green), .pix_blue(pix_blue)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endtask

  // Behavioural model: walking is tracked as a pulse count since walking began
  logic [9:0]  m_sx, m_sy;
  logic [1:0]  m_smd;
  logic        m_walk, m_left;
  int          m_cnt;
  logic [11:0] m_addr;
  logic        s1_v, s1_h;

  task automatic cyc(input logic fs, input logic dv, input logic [9:0] dx_, input logic [9:0] dy_,
                     input logic [9:0] px, input logic [9:0] py, input logic [1:0] md, input logic rst);
    int ddx, ddy, col, fr, idx;
    logic hit0, ev, eh;
    logic [11:0] a0, ergb;
    frame_start = fs; draw_valid = dv; draw_x = dx_; draw_y = dy_;
    pos_x = px; pos_y = py; move_dir = md; Reset = rst;
    ddx  = int'(dx_) - int'(m_sx);
    ddy  = int'(dy_) - int'(m_sy);
    hit0 = dv && ddx >= 0 && ddx < SW && ddy >= 0 && ddy < SH;
    fr   = !m_walk ? 0 : (((m_cnt / DIV) % 2 == 0) ? 1 : 2);
    col  = m_left ? (SW - 1 - ddx) : ddx;
    a0   = 12'(fr * 1024 + ddy * SW + col);
    idx  = int'(rom_mem[m_addr]);
    ev   = s1_v;
    eh   = s1_h && idx != 0;
    ergb = eh ? pal_tab[idx] : 12'h000;
    @(posedge Clk); #1;
    if (rst) begin
      m_sx = '0; m_sy = '0; m_smd = 2'b00; m_walk = 1'b0; m_left = 1'b0; m_cnt = 0;
      m_addr = '0; s1_v = 1'b0; s1_h = 1'b0;
      ev = 1'b0; eh = 1'b0; ergb = '0;
    end else begin
      if (hit0) m_addr = a0;
      s1_v = dv;
      s1_h = hit0;
      if (fs) begin
        if (m_smd == 2'b01 || m_smd == 2'b10) begin
          m_left = (m_smd == 2'b01);
          if (!m_walk) begin m_walk = 1'b1; m_cnt = 0; end
          else m_cnt++;
        end else begin
          m_walk = 1'b0;
        end
        m_sx = px; m_sy = py; m_smd = md;
      end
    end
    chk("model_rom_addr", rom_addr, m_addr);
    chk("model_pix_valid", pix_valid, ev);
    chk("model_pix_hit", pix_hit, eh);
    chk("model_pix_rgb", {pix_red, pix_green, pix_blue}, ergb);
  endtask

  typedef struct {
    logic [9:0]  px, py, dx, dy;
    logic        dv, ehit;
    logic [11:0] eaddr;
  } vec_t;

  vec_t vt [10];

  logic [1:0] exp_fr [6];

  initial begin
    m_sx = '0; m_sy = '0; m_smd = '0; m_walk = 0; m_left = 0; m_cnt = 0;
    m_addr = '0; s1_v = 0; s1_h = 0;
    for (int i = 0; i < 4096; i++) rom_mem[i] = 4'($urandom_range(1, 15));
    for (int i = 0; i < 16; i++) pal_tab[i] = 12'($urandom_range(1, 4095));

    // Facing right, IDLE frame; misses must leave rom_addr holding
    vt[0] = '{10'd100, 10'd50,  10'd103, 10'd52,  1'b1, 1'b1, 12'h043};
    vt[1] = '{10'd630, 10'd470, 10'd639, 10'd479, 1'b1, 1'b1, 12'h129};
    vt[2] = '{10'd630, 10'd470, 10'd629, 10'd479, 1'b1, 1'b0, 12'h129};
    vt[3] = '{10'd0,   10'd0,   10'd31,  10'd31,  1'b1, 1'b1, 12'h3FF};
    vt[4] = '{10'd0,   10'd0,   10'd32,  10'd0,   1'b1, 1'b0, 12'h3FF};
    vt[5] = '{10'd1010, 10'd1010, 10'd5, 10'd5,   1'b1, 1'b0, 12'h3FF};
    vt[6] = '{10'd620, 10'd0,   10'd639, 10'd0,   1'b1, 1'b1, 12'h013};
    vt[7] = '{10'd0,   10'd0,   10'd1,   10'd1,   1'b0, 1'b0, 12'h013};
    vt[8] = '{10'd0,   10'd0,   10'd0,   10'd31,  1'b1, 1'b1, 12'h3E0};
    vt[9] = '{10'd500, 10'd200, 10'd500, 10'd232, 1'b1, 1'b0, 12'h3E0};

    exp_fr[0] = 2'b00; exp_fr[1] = 2'b01; exp_fr[2] = 2'b01;
    exp_fr[3] = 2'b10; exp_fr[4] = 2'b10; exp_fr[5] = 2'b01;

    // Reset state and first-pixel latency
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_pix_hit", pix_hit, 0);
    chk("rst_rgb", {pix_red, pix_green, pix_blue}, 0);
    chk("rst_rom_addr", rom_addr, 12'h000);
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    chk("lat1_rom_addr", rom_addr, 12'h000);
    chk("lat1_pix_valid", pix_valid, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("lat2_pix_valid", pix_valid, 1);
    chk("lat2_pix_hit", pix_hit, 1);

    // Directed vector table
    for (int i = 0; i < 10; i++) begin
      cyc(1, 0, 0, 0, vt[i].px, vt[i].py, 2'b00, 0);
      cyc(0, vt[i].dv, vt[i].dx, vt[i].dy, vt[i].px, vt[i].py, 2'b00, 0);
      chk("tab_rom_addr", rom_addr, vt[i].eaddr);
      cyc(0, 0, 0, 0, vt[i].px, vt[i].py, 2'b00, 0);
      chk("tab_pix_valid", pix_valid, vt[i].dv);
      chk("tab_pix_hit", pix_hit, vt[i].ehit);
      if (!vt[i].ehit) chk("tab_rgb_zero", {pix_red, pix_green, pix_blue}, 0);
    end

    // Mirror: face left then return to IDLE, then face right again
    cyc(1, 0, 0, 0, 100, 50, 2'b01, 0);
    cyc(1, 0, 0, 0, 100, 50, 2'b00, 0);
    cyc(1, 0, 0, 0, 100, 50, 2'b00, 0);
    cyc(0, 1, 103, 52, 100, 50, 2'b00, 0);
    chk("mirror_left", rom_addr, 12'h05C);
    cyc(1, 0, 0, 0, 100, 50, 2'b10, 0);
    cyc(1, 0, 0, 0, 100, 50, 2'b00, 0);
    cyc(1, 0, 0, 0, 100, 50, 2'b00, 0);
    cyc(0, 1, 103, 52, 100, 50, 2'b00, 0);
    chk("mirror_right", rom_addr, 12'h043);

    // Animation with ANIM_DIV=2 and move_dir=10 held
    for (int i = 0; i < 6; i++) begin
      cyc(1, 0, 0, 0, 0, 0, 2'b10, 0);
      cyc(0, 1, 1, 1, 0, 0, 2'b10, 0);
      chk("anim_frame", rom_addr[11:10], exp_fr[i]);
    end
    cyc(1, 0, 0, 0, 0, 0, 2'b00, 0);
    cyc(0, 1, 1, 1, 0, 0, 2'b00, 0);
    cyc(1, 0, 0, 0, 0, 0, 2'b00, 0);
    cyc(0, 1, 1, 1, 0, 0, 2'b00, 0);
    chk("anim_idle_frame", rom_addr[11:10], 2'b00);

    // Transparency, then opaque index whose palette entry is black
    rom_mem[12'h062] = 4'h0;
    cyc(0, 1, 2, 3, 0, 0, 2'b00, 0);
    cyc(0, 0, 0, 0, 0, 0, 2'b00, 0);
    chk("transp_valid", pix_valid, 1);
    chk("transp_hit", pix_hit, 0);
    chk("transp_rgb", {pix_red, pix_green, pix_blue}, 0);
    rom_mem[12'h062] = 4'hB;
    pal_tab[11] = 12'h000;
    cyc(0, 1, 2, 3, 0, 0, 2'b00, 0);
    cyc(0, 0, 0, 0, 0, 0, 2'b00, 0);
    chk("black_hit", pix_hit, 1);
    chk("black_rgb", {pix_red, pix_green, pix_blue}, 0);

    // frame_start coinciding with a draw: old position applies to that pixel
    cyc(1, 1, 5, 5, 200, 0, 2'b00, 0);
    cyc(0, 1, 5, 5, 200, 0, 2'b00, 0);
    chk("coin_old_hit", pix_hit, 1);
    cyc(0, 0, 0, 0, 200, 0, 2'b00, 0);
    chk("coin_new_valid", pix_valid, 1);
    chk("coin_new_hit", pix_hit, 0);

    // Reset mid-line drops in-flight pixels
    cyc(0, 1, 210, 10, 200, 0, 2'b00, 0);
    cyc(0, 1, 211, 10, 200, 0, 2'b00, 1);
    chk("rst_mid_valid", pix_valid, 0);
    chk("rst_mid_addr", rom_addr, 12'h000);
    cyc(0, 0, 0, 0, 0, 0, 2'b00, 0);
    chk("rst_mid_valid2", pix_valid, 0);

    // Randomized run against the model
    for (int i = 0; i < 4096; i++) rom_mem[i] = 4'($urandom_range(0, 15));
    for (int i = 0; i < 16; i++) pal_tab[i] = 12'($urandom);
    for (int i = 0; i < 3000; i++) begin
      logic [9:0] rx, ry, rpx, rpy;
      rx  = 10'(int'(m_sx) + int'($urandom_range(0, 47)) - 8);
      ry  = 10'(int'(m_sy) + int'($urandom_range(0, 47)) - 8);
      rpx = 10'($urandom);
      rpy = 10'($urandom);
      cyc(($urandom % 8) == 0, ($urandom % 4) != 0, rx, ry, rpx, rpy,
          2'($urandom), ($urandom % 500) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
